// File: rtl/fifo_pkg.sv
// Shared defaults for the arbitrated FIFO controller and its storage.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned DEPTH_DEF        = 8;
    localparam int unsigned AFULL_THRESH_DEF = 6;
    localparam int unsigned PTR_W_DEF        = $clog2(DEPTH_DEF);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int unsigned DEPTH  = fifo_pkg::DEPTH_DEF,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Two-requester round-robin write arbiter in front of a fall-through FIFO.
module fifo_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned AFULL_THRESH = AFULL_THRESH_DEF,
    parameter int unsigned PTR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_valid,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              almost_full
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              rr_q, rr_d;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_rdata;

    assign full        = (count_q == (PTR_W+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= (PTR_W+1)'(AFULL_THRESH));
    assign count       = count_q;
    assign rd_valid    = !empty;
    assign rd_data     = empty ? '0 : mem_rdata;

    // rr_q=0 favours requester 0 when both are valid; full blocks both even if a read is pending.
    always_comb begin
        wr0_ready = !full && wr0_valid && (!wr1_valid || !rr_q);
        wr1_ready = !full && wr1_valid && (!wr0_valid ||  rr_q);
        wr_en     = (wr0_valid && wr0_ready) || (wr1_valid && wr1_ready);
        wr_data   = wr1_ready ? wr1_data : wr0_data;
        rd_en     = rd_valid && rd_ready;
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rr_d     = wr_en ? !rr_q : rr_q;
        count_d  = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

endmodule
